// File: rtl/axi_dma_pkg.sv
// rtl/axi_dma_pkg.sv - shared types and constants for the DMA ring sequencer
//
// Purpose: sequencer state encoding, DRAM burst alignment and the writer
// acknowledge timeout used by axi_dma_ring_sequencer.
// Ports: none (package).

package axi_dma_pkg;

  // Addresses and chunk sizes are multiples of 128 bytes.
  localparam int DMA_ALIGN_BITS = 7;

  // Cycles ACK waits for txn_busy before declaring the writer dead.
  localparam int ACK_TIMEOUT = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    RUN,
    FULL
  } state_t;

endpackage

// File: rtl/axi_dma_ring_sequencer.sv
// rtl/axi_dma_ring_sequencer.sv - issues one DMA writer transaction per ring chunk
//
// Purpose: streams data into a circular ring of fixed-size DRAM chunks by
// driving the writer's txn_* control ports, wrapping the chunk address,
// counting completed-but-unreleased chunks and stalling when the ring is full.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_base            ring base byte address (bits 6:0 ignored)
//   cfg_chunk_bytes     chunk size in bytes (bits 6:0 ignored)
//   cfg_chunk_count     chunks in the ring
//   enable              level, run while high
//   release_chunk       one-cycle pulse, software consumed one chunk
//   txn_addr/txn_count  writer transaction address and byte count
//   txn_start           one-cycle writer start pulse
//   txn_busy            writer busy
//   running             high while not IDLE
//   chunk_done          one-cycle pulse per completed chunk
//   wr_index            index of the next chunk to be written
//   fill                completed chunks not yet released
//   stall_cycles        cycles spent FULL since the last start
//   err                 sticky error flag

module axi_dma_ring_sequencer
  import axi_dma_pkg::*;
#(
  parameter int IDXW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     cfg_base,
  input  logic [31:0]     cfg_chunk_bytes,
  input  logic [IDXW-1:0] cfg_chunk_count,
  input  logic            enable,
  input  logic            release_chunk,
  output logic [31:0]     txn_addr,
  output logic [31:0]     txn_count,
  output logic            txn_start,
  input  logic            txn_busy,
  output logic            running,
  output logic            chunk_done,
  output logic [IDXW-1:0] wr_index,
  output logic [IDXW-1:0] fill,
  output logic [31:0]     stall_cycles,
  output logic            err
);

  localparam int AB = DMA_ALIGN_BITS;

  state_t          state_q, state_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     chunk_q, chunk_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     stall_q, stall_d;
  logic [IDXW-1:0] count_q, count_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] fill_q, fill_d;
  logic [2:0]      ack_q, ack_d;
  logic            err_q, err_d;
  logic            block_q, block_d;
  logic            done_q, done_d;
  logic            start_q;
  logic            comp;
  logic            cfg_bad;
  logic            unused_cfg_bits;

  assign unused_cfg_bits = ^{cfg_base[AB-1:0], cfg_chunk_bytes[AB-1:0]};

  // The writer has finished the chunk this cycle.
  assign comp    = (state_q == RUN) && !txn_busy;
  assign cfg_bad = (cfg_chunk_count == '0) || (cfg_chunk_bytes[22:AB] == '0);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    chunk_d = chunk_q;
    addr_d  = addr_q;
    stall_d = stall_q;
    count_d = count_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    ack_d   = ack_q;
    err_d   = err_q;
    block_d = block_q;
    done_d  = 1'b0;

    // A rejected start or dead writer holds off restarts until enable drops.
    if (!enable) block_d = 1'b0;

    // A release coinciding with a completion cancels out: the released
    // chunk is the one that just finished.
    if (release_chunk) begin
      if (!comp) begin
        if (fill_q != '0) fill_d = fill_q - IDXW'(1);
        else              err_d  = 1'b1;
      end
    end else if (comp) begin
      fill_d = fill_q + IDXW'(1);
    end

    case (state_q)
      IDLE: begin
        if (enable && !block_q) begin
          base_d  = {cfg_base[31:AB], {AB{1'b0}}};
          chunk_d = {cfg_chunk_bytes[31:AB], {AB{1'b0}}};
          count_d = cfg_chunk_count;
          if (cfg_bad) begin
            err_d   = 1'b1;
            block_d = 1'b1;
          end else begin
            addr_d  = {cfg_base[31:AB], {AB{1'b0}}};
            idx_d   = '0;
            fill_d  = '0;
            stall_d = '0;
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        ack_d   = '0;
        state_d = ACK;
      end
      ACK: begin
        if (txn_busy) begin
          state_d = RUN;
        end else if (ack_q == 3'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          block_d = 1'b1;
          state_d = IDLE;
        end else begin
          ack_d = ack_q + 3'd1;
        end
      end
      RUN: begin
        if (comp) begin
          done_d = 1'b1;
          if (idx_q == count_q - IDXW'(1)) begin
            idx_d  = '0;
            addr_d = base_q;
          end else begin
            idx_d  = idx_q + IDXW'(1);
            addr_d = addr_q + chunk_q;
          end
          if (enable && (fill_d < count_q)) state_d = ISSUE;
          else if (enable)                  state_d = FULL;
          else                              state_d = IDLE;
        end
      end
      FULL: begin
        if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
        if (enable && (fill_q < count_q)) state_d = ISSUE;
        else if (!enable)                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      chunk_q <= '0;
      addr_q  <= '0;
      stall_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      block_q <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      chunk_q <= chunk_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      block_q <= block_d;
      done_q  <= done_d;
      start_q <= (state_d == ISSUE);
    end
  end

  assign txn_addr     = addr_q;
  assign txn_count    = chunk_q;
  assign txn_start    = start_q;
  assign running      = (state_q != IDLE);
  assign chunk_done   = done_q;
  assign wr_index     = idx_q;
  assign fill         = fill_q;
  assign stall_cycles = stall_q;
  assign err          = err_q;

endmodule

// File: tb/tb_axi_dma_ring_sequencer.sv
// tb/tb_axi_dma_ring_sequencer.sv - self-checking bench for axi_dma_ring_sequencer

module tb_axi_dma_ring_sequencer;

  localparam int IDXW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     cfg_base = '0;
  logic [31:0]     cfg_chunk_bytes = '0;
  logic [IDXW-1:0] cfg_chunk_count = '0;
  logic            enable = 1'b0;
  logic            release_chunk = 1'b0;
  logic [31:0]     txn_addr;
  logic [31:0]     txn_count;
  logic            txn_start;
  logic            txn_busy = 1'b0;
  logic            running;
  logic            chunk_done;
  logic [IDXW-1:0] wr_index;
  logic [IDXW-1:0] fill;
  logic [31:0]     stall_cycles;
  logic            err;

  axi_dma_ring_sequencer #(.IDXW(IDXW)) dut (
    .clk(clk), .reset(reset),
    .cfg_base(cfg_base), .cfg_chunk_bytes(cfg_chunk_bytes), .cfg_chunk_count(cfg_chunk_count),
    .enable(enable), .release_chunk(release_chunk),
    .txn_addr(txn_addr), .txn_count(txn_count), .txn_start(txn_start), .txn_busy(txn_busy),
    .running(running), .chunk_done(chunk_done), .wr_index(wr_index), .fill(fill),
    .stall_cycles(stall_cycles), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- writer model ----------------
  bit w_dead = 0, w_rand = 0, st_s = 0, w_fell = 0;
  int w_pend = 0, w_left = 0, w_len = 3, w_lat = 1;

  always @(negedge clk) if (txn_start) st_s = 1;

  always @(posedge clk) begin
    #1;
    w_fell = 0;
    if (txn_busy) begin
      w_left--;
      if (w_left == 0) begin txn_busy = 1'b0; w_fell = 1; end
    end else if (w_pend > 0) begin
      w_pend--;
      if (w_pend == 0) begin txn_busy = 1'b1; w_left = w_len; end
    end
    if (st_s) begin
      st_s = 0;
      if (w_rand) begin
        w_len = $urandom_range(1, 6);
        w_lat = ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(1, 4);
      end
      if (!w_dead) begin
        if (w_lat == 1) begin txn_busy = 1'b1; w_left = w_len; end
        else w_pend = w_lat - 1;
      end
    end
  end

  // ---------------- behavioural reference ----------------
  // Chunk address is derived as base + index * chunk rather than tracked.
  bit          m_on, m_start, m_txn, m_full, m_block, m_done, m_err;
  int          m_ack, m_fill, m_idx, m_count;
  logic [31:0] m_stall, m_gbase, m_gchunk, m_lchunk;

  always @(posedge clk) begin : model
    bit comp;
    bit go;
    int nf;
    if (reset) begin
      m_on = 0; m_start = 0; m_txn = 0; m_full = 0; m_block = 0; m_done = 0; m_err = 0;
      m_ack = 0; m_fill = 0; m_idx = 0; m_count = 0;
      m_stall = '0; m_gbase = '0; m_gchunk = '0; m_lchunk = '0;
    end else begin
      comp = m_txn && !txn_busy;
      m_done = comp;
      nf = m_fill;
      if (release_chunk && !comp) begin
        if (m_fill > 0) nf = m_fill - 1;
        else m_err = 1;
      end else if (comp && !release_chunk) begin
        nf = m_fill + 1;
      end
      if (!enable) m_block = 0;
      go = 0;
      if (!m_on) begin
        if (enable && !m_block) begin
          m_lchunk = {cfg_chunk_bytes[31:7], 7'd0};
          if (cfg_chunk_count == 0 || cfg_chunk_bytes[22:7] == 0) begin
            m_err = 1; m_block = 1;
          end else begin
            m_gbase = {cfg_base[31:7], 7'd0};
            m_gchunk = m_lchunk;
            m_count = int'(cfg_chunk_count);
            m_idx = 0; nf = 0; m_stall = '0; m_err = 0; m_on = 1; go = 1;
          end
        end
      end else if (m_start) begin
        m_ack = 1;
      end else if (m_ack > 0) begin
        if (txn_busy) begin m_ack = 0; m_txn = 1; end
        else if (m_ack == 4) begin m_ack = 0; m_err = 1; m_block = 1; m_on = 0; end
        else m_ack++;
      end else if (m_txn) begin
        if (comp) begin
          m_txn = 0;
          m_idx = (m_idx + 1) % m_count;
          if (enable && nf < m_count) go = 1;
          else if (enable) m_full = 1;
          else m_on = 0;
        end
      end else if (m_full) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (enable && m_fill < m_count) begin m_full = 0; go = 1; end
        else if (!enable) begin m_full = 0; m_on = 0; end
      end
      m_fill = nf;
      m_start = go;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("txn_start", txn_start, m_start);
      chk("txn_addr", txn_addr, m_gbase + 32'(m_idx) * m_gchunk);
      chk("txn_count", txn_count, m_lchunk);
      chk("running", running, m_on);
      chk("chunk_done", chunk_done, m_done);
      chk("wr_index", wr_index, m_idx);
      chk("fill", fill, m_fill);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("err", err, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit auto_rel = 0, rnd_rel = 0;
  logic [31:0] sq[$];
  int          iq[$];

  task automatic tick();
    @(negedge clk);
    release_chunk = (auto_rel && chunk_done) || (rnd_rel && ($urandom_range(0, 4) == 0));
    if (txn_start) begin sq.push_back(txn_addr); iq.push_back(int'(wr_index)); end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return txn_start;
      1: return chunk_done;
      2: return !running && !txn_busy && w_pend == 0;
      3: return w_fell;
      4: return txn_busy;
      5: return !txn_busy && w_pend == 0 && !txn_start;
      default: return 0;
    endcase
  endfunction

  task automatic wait_until(input int which, input int lim, input string name);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (cond(which)) begin ok = 1; break; end
    end
    chk({"wait_", name}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    wait_until(5, 100, "writer_idle");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [31:0] t1_addr[5] = '{32'h1000_0000, 32'h1000_0800, 32'h1000_1000, 32'h1000_1800, 32'h1000_0000};
  int          t1_idx[5]  = '{0, 1, 2, 3, 0};

  initial begin
    int n0;
    repeat (3) tick();
    cmp_en = 1;
    reset = 1'b0;
    tick();
    chk("rst_running", running, 0);
    chk("rst_fill", fill, 0);
    chk("rst_addr", txn_addr, 0);
    chk("rst_err", err, 0);

    // Ring walk with prompt release: address and index wrap.
    cfg_base = 32'h1000_0000; cfg_chunk_bytes = 32'h800; cfg_chunk_count = 4;
    auto_rel = 1; sq.delete(); iq.delete();
    enable = 1'b1;
    for (int k = 0; k < 5; k++) wait_until(0, 60, "t1_start");
    chk("t1_nstarts", 32'(sq.size() >= 5), 1);
    if (sq.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t1_addr", sq[k], t1_addr[k]);
        chk("t1_idx", 32'(iq[k]), 32'(t1_idx[k]));
      end
    end
    chk("t1_count", txn_count, 32'h800);
    enable = 1'b0;
    wait_until(2, 100, "t1_idle");

    // count=2, no release: fills, stalls, resumes after one release.
    do_reset();
    auto_rel = 0;
    cfg_base = 32'h2000_0000; cfg_chunk_bytes = 32'h100; cfg_chunk_count = 2;
    enable = 1'b1;
    wait_until(1, 60, "t2_done1");
    wait_until(1, 60, "t2_done2");
    chk("t2_fill_full", fill, 2);
    chk("t2_stall0", stall_cycles, 0);
    repeat (5) tick();
    chk("t2_stall5", stall_cycles, 5);
    chk("t2_running", running, 1);
    chk("t2_no_start", txn_start, 0);
    release_chunk = 1'b1;
    tick();
    chk("t2_fill_rel", fill, 1);
    tick();
    chk("t2_restart", txn_start, 1);
    enable = 1'b0;
    wait_until(2, 100, "t2_idle");

    // Release on the completion cycle leaves fill unchanged.
    do_reset();
    cfg_base = 32'h0; cfg_chunk_bytes = 32'h80; cfg_chunk_count = 4;
    enable = 1'b1;
    wait_until(1, 60, "t3_done1");
    chk("t3_fill1", fill, 1);
    wait_until(3, 60, "t3_fall");
    release_chunk = 1'b1;
    tick();
    chk("t3_done_rel", chunk_done, 1);
    chk("t3_fill_same", fill, 1);
    enable = 1'b0;
    wait_until(2, 100, "t3_idle");
    chk("t3_fill_idle", fill, 2);
    chk("t3_idx_idle", wr_index, 3);
    release_chunk = 1'b1; tick();
    release_chunk = 1'b1; tick();
    chk("t3_fill_zero", fill, 0);
    chk("t3_err_clean", err, 0);
    release_chunk = 1'b1; tick();
    chk("t3_err_underflow", err, 1);
    chk("t3_fill_held", fill, 0);

    // Enable dropped mid-transaction: one final completion, then idle.
    do_reset();
    auto_rel = 1;
    cfg_base = 32'h4000_0000; cfg_chunk_bytes = 32'h80; cfg_chunk_count = 4;
    enable = 1'b1;
    wait_until(4, 20, "t4_busy");
    enable = 1'b0;
    n0 = sq.size();
    wait_until(1, 20, "t4_done");
    chk("t4_stopped", running, 0);
    chk("t4_fill", fill, 1);
    repeat (10) tick();
    chk("t4_no_more_start", 32'(sq.size()), 32'(n0));

    // Bad configurations are rejected; a good start clears err.
    do_reset();
    n0 = sq.size();
    cfg_chunk_count = 0; cfg_chunk_bytes = 32'h800;
    enable = 1'b1;
    repeat (4) tick();
    chk("t5_err_cnt0", err, 1);
    chk("t5_idle_cnt0", running, 0);
    enable = 1'b0; tick();
    cfg_chunk_count = 3; cfg_chunk_bytes = 32'h40;
    enable = 1'b1;
    repeat (4) tick();
    chk("t5_err_small", err, 1);
    chk("t5_no_start", 32'(sq.size()), 32'(n0));
    enable = 1'b0; tick();
    chk("t5_err_sticky", err, 1);
    cfg_chunk_bytes = 32'h800;
    enable = 1'b1;
    wait_until(0, 3, "t5_start");
    chk("t5_err_cleared", err, 0);
    enable = 1'b0;
    wait_until(2, 100, "t5_idle");

    // Writer never answers: timeout after four ACK cycles.
    do_reset();
    w_dead = 1;
    enable = 1'b1;
    wait_until(0, 3, "t6_start");
    repeat (4) tick();
    chk("t6_still_waiting", running, 1);
    chk("t6_err_pending", err, 0);
    tick();
    chk("t6_timeout_idle", running, 0);
    chk("t6_timeout_err", err, 1);
    repeat (3) tick();
    chk("t6_held_off", running, 0);
    w_dead = 0;
    enable = 1'b0;
    tick();

    // Randomised traffic against the reference.
    do_reset();
    w_rand = 1; rnd_rel = 1; auto_rel = 0;
    for (int c = 0; c < 4000; c++) begin
      int r;
      tick();
      r = $urandom_range(0, 99);
      if (r < 3) begin
        enable = !enable;
      end else if (r < 6) begin
        cfg_base = $urandom;
        cfg_chunk_count = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
        cfg_chunk_bytes = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 127))
                        : ((32'($urandom_range(1, 8)) << 7) | 32'($urandom_range(0, 127)));
      end else if (r == 99 && cond(5)) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    rnd_rel = 0;
    enable = 1'b0;
    wait_until(2, 200, "rand_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
